fir_output_power_meter: RTL and testbench
=========================================

FIR_OUTPUT_POWER_METER -- requirements
Module: fir_output_power_meter

Interface
REQ-001 Parameter IN_WIDTH, default 32: width of signed FIR output samples consumed.
REQ-002 Parameter LOG2_N, default 10: window length N = 2^LOG2_N accepted samples.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a new measurement window.
REQ-006 data_valid  input  1  data_in carries a sample this cycle.
REQ-007 data_in  input  IN_WIDTH  signed FIR filter output sample.
REQ-008 busy  output  1  high while a window is being accumulated or drained.
REQ-009 done  output  1  one-cycle pulse, result outputs updated this cycle.
REQ-010 sum_out  output  IN_WIDTH+LOG2_N  signed sum of window samples.
REQ-011 sumsq_out  output  2*IN_WIDTH+LOG2_N  unsigned sum of squared samples.
REQ-012 peak_abs_out  output  IN_WIDTH  unsigned maximum |sample| in window.

Function
REQ-013 FSM states SHALL be IDLE, ACCUM, FLUSH, DONE.
REQ-014 IDLE or DONE with start=1 SHALL clear sample counter, accumulators and peak tracker, then enter ACCUM.
REQ-015 Sample in the start cycle SHALL NOT be accepted; first acceptable sample is the following cycle.
REQ-016 In ACCUM a sample SHALL be accepted iff data_valid=1; data_valid=0 cycles SHALL not advance the counter.
REQ-017 Stage 1 SHALL register the sample, its square (full 2*IN_WIDTH precision) and its absolute value; stage 2 SHALL add them into the accumulators.
REQ-018 |-(2^(IN_WIDTH-1))| SHALL equal 2^(IN_WIDTH-1), representable unsigned in IN_WIDTH bits.
REQ-019 Sum SHALL sign-extend into IN_WIDTH+LOG2_N bits; sumsq zero-extends; neither SHALL overflow for N samples.
REQ-020 After the Nth accepted sample ACCUM SHALL go to FLUSH for one cycle, then DONE for one cycle, then IDLE.
REQ-021 done SHALL be 1 exactly in the DONE state, two cycles after the cycle the Nth sample is accepted.
REQ-022 Result outputs SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-023 busy SHALL be 1 in ACCUM and FLUSH, 0 in IDLE and DONE.
REQ-024 start in ACCUM or FLUSH SHALL be ignored with no effect on the window in progress.
REQ-025 start in DONE SHALL begin a new window while done and results still reflect the completed window.
REQ-026 data_valid outside ACCUM SHALL be ignored.

Reset
REQ-027 rst=1 SHALL asynchronously force state IDLE, counter, accumulators, peak, busy, done, sum_out, sumsq_out, peak_abs_out to 0.
REQ-028 Reset mid-window SHALL discard the partial window; no done pulse SHALL follow.

Structure
REQ-029 Package fir_meter_pkg SHALL hold the FSM state type and default IN_WIDTH/LOG2_N constants.
REQ-030 The stage-1 register/square/abs logic SHALL be sub-module fir_meter_square_stage.

Verification (IN_WIDTH=32, LOG2_N=2, N=4)
REQ-031 start, then 4 consecutive valid samples of +3 -> done two cycles after 4th; sum 12, sumsq 36, peak 3.
REQ-032 Samples -2^31, 0, 0, 0 -> sum -2^31, sumsq 2^62, peak 2^31.
REQ-033 Samples 5,-7,1,2 with valid low between each -> sum 1, sumsq 79, peak 7; only 4 samples counted.
REQ-034 start pulsed mid-ACCUM -> ignored; window completes with original samples, single done.
REQ-035 rst asserted after 2 samples -> all outputs 0, IDLE, no done; new start then 4x(-1) -> sum -4, sumsq 4, peak 1.
REQ-036 start asserted in the DONE cycle -> new window begins, busy=1 next cycle, prior results held until next done.

Source files
------------

// File: rtl/fir_meter_pkg.sv
// Shared types and default sizing for the FIR output power meter.
//   meter_state_e : measurement FSM state type
//   DefInWidth    : default sample width
//   DefLog2N      : default log2 of the window length
package fir_meter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } meter_state_e;

    localparam int unsigned DefInWidth = 32;
    localparam int unsigned DefLog2N   = 10;

endpackage

// File: rtl/fir_output_power_meter_if.sv
// Bus between a sample source/controller and the power meter.
//   master : drives start, data_valid, data_in; observes status and results
//   slave  : the meter itself
interface fir_output_power_meter_if #(
    parameter int unsigned IN_WIDTH = fir_meter_pkg::DefInWidth,
    parameter int unsigned LOG2_N   = fir_meter_pkg::DefLog2N
);
    logic                                start;
    logic                                data_valid;
    logic signed [IN_WIDTH-1:0]          data_in;
    logic                                busy;
    logic                                done;
    logic signed [IN_WIDTH+LOG2_N-1:0]   sum_out;
    logic        [2*IN_WIDTH+LOG2_N-1:0] sumsq_out;
    logic        [IN_WIDTH-1:0]          peak_abs_out;

    modport master (
        output start, data_valid, data_in,
        input  busy, done, sum_out, sumsq_out, peak_abs_out
    );

    modport slave (
        input  start, data_valid, data_in,
        output busy, done, sum_out, sumsq_out, peak_abs_out
    );
endinterface

// File: rtl/fir_meter_square_stage.sv
// First pipeline stage: registers an accepted sample with its full-precision
// square and its magnitude.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : in_data is an accepted sample
//   in_data    : signed sample
//   out_valid  : registered outputs carry a sample this cycle
//   out_sample : registered sample
//   out_square : registered sample^2 (unsigned, 2*IN_WIDTH bits)
//   out_abs    : registered |sample| (unsigned, IN_WIDTH bits)
module fir_meter_square_stage #(
    parameter int unsigned IN_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [IN_WIDTH-1:0]   in_data,
    output logic                         out_valid,
    output logic signed [IN_WIDTH-1:0]   out_sample,
    output logic        [2*IN_WIDTH-1:0] out_square,
    output logic        [IN_WIDTH-1:0]   out_abs
);
    logic signed [2*IN_WIDTH-1:0] square_c;
    logic        [IN_WIDTH-1:0]   abs_c;
    logic        [IN_WIDTH-1:0]   data_u;

    // Both operands widen to 2*IN_WIDTH signed before multiplying, so the
    // square is exact; it is never negative so the bits read as unsigned.
    assign square_c = in_data * in_data;
    assign data_u   = in_data;
    // Two's complement negate; the most negative value maps to 2^(IN_WIDTH-1),
    // which is correct when read as unsigned.
    assign abs_c    = in_data[IN_WIDTH-1] ? (~data_u + {{(IN_WIDTH-1){1'b0}}, 1'b1}) : data_u;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_square <= '0;
            out_abs    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_sample <= in_data;
                out_square <= square_c;
                out_abs    <= abs_c;
            end
        end
    end
endmodule

// File: rtl/fir_output_power_meter.sv
// Measures sum, sum of squares and peak magnitude over a window of
// N = 2^LOG2_N accepted FIR output samples.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of fir_output_power_meter_if
//              start/data_valid/data_in in; busy/done/results out
module fir_output_power_meter
    import fir_meter_pkg::*;
#(
    parameter int unsigned IN_WIDTH = DefInWidth,
    parameter int unsigned LOG2_N   = DefLog2N
) (
    input logic                      clk,
    input logic                      rst,
    fir_output_power_meter_if.slave  bus
);
    localparam int unsigned SumW = IN_WIDTH + LOG2_N;
    localparam int unsigned SqW  = 2 * IN_WIDTH + LOG2_N;

    meter_state_e state_q, state_d;

    logic        [LOG2_N-1:0]     count_q, count_d;
    logic signed [SumW-1:0]       sum_q, sum_d;
    logic        [SqW-1:0]        sumsq_q, sumsq_d;
    logic        [IN_WIDTH-1:0]   peak_q, peak_d;

    logic signed [SumW-1:0]       sum_out_q;
    logic        [SqW-1:0]        sumsq_out_q;
    logic        [IN_WIDTH-1:0]   peak_out_q;

    logic                         accept;
    logic                         last;
    logic                         clear;

    logic                         s1_valid;
    logic signed [IN_WIDTH-1:0]   s1_sample;
    logic        [2*IN_WIDTH-1:0] s1_square;
    logic        [IN_WIDTH-1:0]   s1_abs;

    assign accept = (state_q == StAccum) && bus.data_valid;
    assign last   = accept && (count_q == {LOG2_N{1'b1}});
    assign clear  = bus.start && ((state_q == StIdle) || (state_q == StDone));

    fir_meter_square_stage #(
        .IN_WIDTH (IN_WIDTH)
    ) u_square_stage (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (accept),
        .in_data    (bus.data_in),
        .out_valid  (s1_valid),
        .out_sample (s1_sample),
        .out_square (s1_square),
        .out_abs    (s1_abs)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StAccum;
            StAccum: if (last)      state_d = StFlush;
            StFlush: state_d = StDone;
            StDone:  state_d = bus.start ? StAccum : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Stage 2. The final sample of a window is still in stage 1 during FLUSH,
    // so results are taken from the next-state values rather than the regs.
    always_comb begin
        count_d = count_q;
        sum_d   = sum_q;
        sumsq_d = sumsq_q;
        peak_d  = peak_q;
        if (clear) begin
            count_d = '0;
            sum_d   = '0;
            sumsq_d = '0;
            peak_d  = '0;
        end else begin
            if (accept) count_d = count_q + 1'b1;
            if (s1_valid) begin
                sum_d   = sum_q + {{LOG2_N{s1_sample[IN_WIDTH-1]}}, s1_sample};
                sumsq_d = sumsq_q + {{LOG2_N{1'b0}}, s1_square};
                if (s1_abs > peak_q) peak_d = s1_abs;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            sum_q       <= '0;
            sumsq_q     <= '0;
            peak_q      <= '0;
            sum_out_q   <= '0;
            sumsq_out_q <= '0;
            peak_out_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
            peak_q  <= peak_d;
            if (state_q == StFlush) begin
                sum_out_q   <= sum_d;
                sumsq_out_q <= sumsq_d;
                peak_out_q  <= peak_d;
            end
        end
    end

    assign bus.busy         = (state_q == StAccum) || (state_q == StFlush);
    assign bus.done         = (state_q == StDone);
    assign bus.sum_out      = sum_out_q;
    assign bus.sumsq_out    = sumsq_out_q;
    assign bus.peak_abs_out = peak_out_q;
endmodule

// File: tb/tb_fir_output_power_meter.sv
module tb_fir_output_power_meter;
    localparam int unsigned W  = 32;
    localparam int unsigned LN = 2;
    localparam int unsigned N  = 4;

    typedef logic signed [W+LN-1:0] sum_t;
    typedef logic [2*W+LN-1:0]      sq_t;

    typedef struct {
        int          s[N];
        int          gap;
        longint      sum;
        sq_t         sumsq;
        logic [31:0] peak;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    fir_output_power_meter_if #(.IN_WIDTH(W), .LOG2_N(LN)) bus ();

    fir_output_power_meter #(
        .IN_WIDTH (W),
        .LOG2_N   (LN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_results(input string name, input longint es, input sq_t eq,
                                 input logic [31:0] ep);
        check({name, "_sum"},   sum_t'(bus.sum_out), sum_t'(es));
        check({name, "_sumsq"}, bus.sumsq_out, eq);
        check({name, "_peak"},  bus.peak_abs_out, ep);
    endtask

    // Reference model: direct arithmetic over the list of accepted samples.
    task automatic model(input int q[$], output longint es, output sq_t eq,
                         output logic [31:0] ep);
        longint v, a, pk;
        es = 0;
        eq = '0;
        pk = 0;
        foreach (q[i]) begin
            v  = longint'(q[i]);
            es = es + v;
            eq = eq + sq_t'(v * v);
            a  = (v < 0) ? -v : v;
            if (a > pk) pk = a;
        end
        ep = pk[31:0];
    endtask

    task automatic begin_window();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic feed(input int s, input int gap, input bit poke_start);
        for (int g = 0; g < gap; g++) begin
            bus.data_valid = 1'b0;
            bus.data_in    = $urandom;
            bus.start      = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        bus.start      = 1'b0;
        bus.data_valid = 1'b1;
        bus.data_in    = s;
        step();
        bus.data_valid = 1'b0;
    endtask

    // Called in the cycle after the last sample was accepted; ends in DONE.
    task automatic wait_done(input string name);
        int lat = 0;
        check({name, "_flush_busy"}, bus.busy, 1'b1);
        check({name, "_flush_done"}, bus.done, 1'b0);
        while (!bus.done && lat < 8) begin
            step();
            lat++;
        end
        check({name, "_done_latency"}, lat, 1);
        check({name, "_done_busy"}, bus.busy, 1'b0);
    endtask

    vec_t vecs[5];

    initial begin
        longint      es, es2;
        sq_t         eq, eq2;
        logic [31:0] ep, ep2;
        int          q[$];
        int          done_seen;

        vecs[0] = '{'{3, 3, 3, 3}, 0, 64'sd12, sq_t'(36), 32'd3};
        vecs[1] = '{'{32'sh8000_0000, 0, 0, 0}, 0, -64'sd2147483648,
                    66'h0_4000_0000_0000_0000, 32'h8000_0000};
        vecs[2] = '{'{5, -7, 1, 2}, 1, 64'sd1, sq_t'(79), 32'd7};
        vecs[3] = '{'{32'sh7fff_ffff, 32'sh7fff_ffff, 32'sh7fff_ffff, 32'sh7fff_ffff}, 0,
                    64'sh1_ffff_fffc, 66'h0_ffff_fffc_0000_0004, 32'h7fff_ffff};
        vecs[4] = '{'{32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000}, 2,
                    -64'sd8589934592, 66'h1_0000_0000_0000_0000, 32'h8000_0000};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        step();
        step();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check_results("rst", 0, '0, '0);
        rst = 1'b0;
        bus.data_valid = 1'b1;
        bus.data_in    = 77;
        step();
        step();
        bus.data_valid = 1'b0;
        check("idle_valid_ignored_busy", bus.busy, 1'b0);

        // Table-driven windows.
        foreach (vecs[v]) begin
            begin_window();
            check($sformatf("vec%0d_busy_accum", v), bus.busy, 1'b1);
            for (int i = 0; i < N; i++) feed(vecs[v].s[i], vecs[v].gap, 1'b0);
            wait_done($sformatf("vec%0d", v));
            check_results($sformatf("vec%0d", v), vecs[v].sum, vecs[v].sumsq, vecs[v].peak);
            step();
            check($sformatf("vec%0d_idle_done", v), bus.done, 1'b0);
            check_results($sformatf("vec%0d_hold", v), vecs[v].sum, vecs[v].sumsq, vecs[v].peak);
        end

        // start pulsed mid-ACCUM while a sample is also presented.
        begin_window();
        feed(1, 0, 1'b0);
        feed(2, 0, 1'b0);
        bus.start = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in = 3;
        step();
        bus.start = 1'b0;
        feed(4, 1, 1'b0);
        wait_done("midstart");
        check_results("midstart", 10, sq_t'(30), 32'd4);
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.done) done_seen++;
        end
        check("midstart_single_done", done_seen, 0);

        // Reset mid-window discards it.
        begin_window();
        feed(100, 0, 1'b0);
        feed(-50, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        check_results("midrst", 0, '0, '0);
        step();
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            bus.data_valid = 1'b1;
            bus.data_in    = 9;
            step();
            if (bus.done || bus.busy) done_seen++;
        end
        bus.data_valid = 1'b0;
        check("midrst_no_done", done_seen, 0);
        begin_window();
        for (int i = 0; i < N; i++) feed(-1, 0, 1'b0);
        wait_done("postrst");
        check_results("postrst", -4, sq_t'(4), 32'd1);

        // start asserted in the DONE cycle.
        q = '{11, -20, 7, 0};
        begin_window();
        foreach (q[i]) feed(q[i], 0, 1'b0);
        wait_done("donestart_a");
        model(q, es, eq, ep);
        check_results("donestart_a", es, eq, ep);
        begin_window();
        check("donestart_busy", bus.busy, 1'b1);
        check("donestart_done", bus.done, 1'b0);
        check_results("donestart_held", es, eq, ep);
        q = '{-3, 1000, -1000, 2};
        foreach (q[i]) begin
            feed(q[i], 1, 1'b0);
            check_results($sformatf("donestart_held%0d", i), es, eq, ep);
        end
        wait_done("donestart_b");
        model(q, es2, eq2, ep2);
        check_results("donestart_b", es2, eq2, ep2);

        // Randomized windows, including spurious start pulses in gaps.
        for (int w = 0; w < 20; w++) begin
            q = {};
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       q.push_back(int'(32'h8000_0000));
                    1:       q.push_back(int'($urandom_range(0, 20)) - 10);
                    default: q.push_back(int'($urandom));
                endcase
            end
            step();
            begin_window();
            foreach (q[i]) feed(q[i], $urandom_range(0, 2), 1'b1);
            wait_done($sformatf("rand%0d", w));
            model(q, es, eq, ep);
            check_results($sformatf("rand%0d", w), es, eq, ep);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
